rgmii_idelay_cal: RTL and testbench

Parametrised RX-timing calibrator for the RGMII front end. It replaces the fixed-value input delays with a swept, runtime-loaded tap setting. It steps a common IDELAY tap value across all RX lanes (rxd plus rx_ctl), scores each tap by counting good and bad received frames, and loads the centre of the longest passing window. It sits between the IDELAYCTRL/IDELAYE2 (VAR_LOAD) instances and the MAC status outputs. It supports manual override.

---
 rtl/rgmii_idelay_cal_pkg.sv | 24 ++
 rtl/rgmii_idelay_cal_if.sv | 54 +++++
 rtl/rgmii_cal_window.sv | 76 +++++++
 rtl/rgmii_idelay_cal.sv | 252 +++++++++++++++++++++++++
 tb/tb_rgmii_idelay_cal.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgmii_idelay_cal_pkg.sv
// rgmii_pkg: shared types for the RGMII RX IDELAY calibrator.
// Holds the FSM state enum, the tap type and counter-width helper.
package rgmii_pkg;

  localparam int TAP_W_DEF = 5;

  typedef logic [TAP_W_DEF-1:0] tap_t;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_PICK
  } rgmii_cal_state_e;

  // Bits needed to hold the values 0..n.
  function automatic int ctr_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rgmii_idelay_cal_if.sv
// rgmii_idelay_cal_if: control/status bundle of the calibrator.
// master = calibrator side, slave = MAC/PHY/IDELAY side.
interface rgmii_idelay_cal_if #(
  parameter int LANES = 5,
  parameter int TAP_W = 5
);

  logic             idelay_rdy;
  logic             cal_start;
  logic             frame_good;
  logic             frame_bad;
  logic             manual_we;
  logic [TAP_W-1:0] manual_tap;
  logic [TAP_W-1:0] tap_out;
  logic [LANES-1:0] tap_ld;
  logic             cal_busy;
  logic             cal_done;
  logic             cal_fail;
  logic [TAP_W-1:0] win_lo;
  logic [TAP_W-1:0] win_hi;

  modport master (
    input  idelay_rdy,
    input  cal_start,
    input  frame_good,
    input  frame_bad,
    input  manual_we,
    input  manual_tap,
    output tap_out,
    output tap_ld,
    output cal_busy,
    output cal_done,
    output cal_fail,
    output win_lo,
    output win_hi
  );

  modport slave (
    output idelay_rdy,
    output cal_start,
    output frame_good,
    output frame_bad,
    output manual_we,
    output manual_tap,
    input  tap_out,
    input  tap_ld,
    input  cal_busy,
    input  cal_done,
    input  cal_fail,
    input  win_lo,
    input  win_hi
  );

endinterface

// File: rtl/rgmii_cal_window.sv
// rgmii_cal_window: tracks the current passing run and the best run.
// In: clr (new sweep), ev (tap verdict), pass, last, tap. Out: best.
module rgmii_cal_window
  import rgmii_pkg::*;
#(
  parameter int TAP_W = TAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ev,
  input  logic             pass,
  input  logic             last,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W-1:0] best_start,
  output logic [TAP_W:0]   best_len
);

  logic [TAP_W-1:0] run_start_q;
  logic [TAP_W-1:0] run_start_d;
  logic [TAP_W:0]   run_len_q;
  logic [TAP_W:0]   run_len_d;
  logic [TAP_W-1:0] best_start_q;
  logic [TAP_W-1:0] best_start_d;
  logic [TAP_W:0]   best_len_q;
  logic [TAP_W:0]   best_len_d;
  logic [TAP_W-1:0] cand_start;
  logic [TAP_W:0]   cand_len;

  always_comb begin
    // run as it stands after this tap's verdict
    cand_start = (run_len_q == '0) ? tap : run_start_q;
    cand_len   = pass ? run_len_q + (TAP_W+1)'(1)
                      : run_len_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    if (clr) begin
      run_start_d  = '0;
      run_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (ev) begin
      if (pass && !last) begin
        run_start_d = cand_start;
        run_len_d   = cand_len;
      end else begin
        // strict compare keeps the lowest window on a tie
        run_len_d = '0;
        if (cand_len > best_len_q) begin
          best_start_d = cand_start;
          best_len_d   = cand_len;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign best_start = best_start_q;
  assign best_len   = best_len_q;

endmodule

// File: rtl/rgmii_idelay_cal.sv
// rgmii_idelay_cal: sweeps one IDELAY tap over all RX lanes, scores
// frames per tap, loads the centre of the longest clean window.
// Ports: clk_int, rst_int (sync, high), bus (rgmii_idelay_cal_if).
module rgmii_idelay_cal
  import rgmii_pkg::*;
#(
  parameter int LANES          = 5,
  parameter int TAP_W          = TAP_W_DEF,
  parameter int DEFAULT_TAP    = 0,
  parameter int SETTLE_CYCLES  = 64,
  parameter int DWELL_FRAMES   = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int MIN_WINDOW     = 4
) (
  input  logic               clk_int,
  input  logic               rst_int,
  rgmii_idelay_cal_if.master bus
);

  localparam int CW = ctr_w(DWELL_FRAMES + 1);
  localparam int SW = ctr_w(SETTLE_CYCLES);
  localparam int TW = ctr_w(TIMEOUT_CYCLES);

  localparam logic [CW-1:0]  CNT_MAX   = '1;
  localparam logic [CW-1:0]  DWELL     = CW'(DWELL_FRAMES);
  localparam logic [CW:0]    DWELL_SUM = (CW+1)'(DWELL_FRAMES);
  localparam logic [SW-1:0]  SET_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TAP_W-1:0] DEF_TAP = TAP_W'(DEFAULT_TAP);
  localparam logic [TAP_W:0] MIN_LEN   = (TAP_W+1)'(MIN_WINDOW);

  rgmii_cal_state_e state_q;
  rgmii_cal_state_e state_d;

  logic [TAP_W-1:0] tap_q;
  logic [TAP_W-1:0] tap_d;
  logic [SW-1:0]    settle_q;
  logic [SW-1:0]    settle_d;
  logic [TW-1:0]    timer_q;
  logic [TW-1:0]    timer_d;
  logic [CW-1:0]    good_q;
  logic [CW-1:0]    good_d;
  logic [CW-1:0]    bad_q;
  logic [CW-1:0]    bad_d;

  logic [TAP_W-1:0] tap_out_q;
  logic [TAP_W-1:0] tap_out_d;
  logic             ld_q;
  logic             ld_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;
  logic             fail_q;
  logic             fail_d;
  logic [TAP_W-1:0] lo_q;
  logic [TAP_W-1:0] lo_d;
  logic [TAP_W-1:0] hi_q;
  logic [TAP_W-1:0] hi_d;

  logic [CW-1:0]    good_inc;
  logic [CW-1:0]    bad_inc;
  logic [CW:0]      sum;
  logic             meas_end;
  logic             pass;
  logic             last;
  logic             win_clr;
  logic             win_ev;
  logic [TAP_W-1:0] best_start;
  logic [TAP_W:0]   best_len;
  logic             best_ok;
  logic [TAP_W-1:0] pick_mid;
  logic [TAP_W-1:0] pick_hi;

  // saturating frame counts as they would be after this cycle
  always_comb begin
    good_inc = good_q;
    bad_inc  = bad_q;
    if (bus.frame_good && good_q != CNT_MAX) begin
      good_inc = good_q + CW'(1);
    end
    if (bus.frame_bad && bad_q != CNT_MAX) begin
      bad_inc = bad_q + CW'(1);
    end
  end

  assign sum      = {1'b0, good_inc} + {1'b0, bad_inc};
  assign meas_end = (sum >= DWELL_SUM) || (timer_q == TMO_LAST);
  assign pass     = (bad_q == '0) && (good_q >= DWELL);
  assign last     = &tap_q;
  assign win_clr  = (state_q == ST_IDLE) && bus.cal_start;
  assign win_ev   = (state_q == ST_EVAL);
  assign best_ok  = best_len >= MIN_LEN;
  assign pick_mid = best_start + best_len[TAP_W:1];
  assign pick_hi  = best_start + TAP_W'(best_len - (TAP_W+1)'(1));

  rgmii_cal_window #(
    .TAP_W (TAP_W)
  ) u_window (
    .clk        (clk_int),
    .rst        (rst_int),
    .clr        (win_clr),
    .ev         (win_ev),
    .pass       (pass),
    .last       (last),
    .tap        (tap_q),
    .best_start (best_start),
    .best_len   (best_len)
  );

  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      state_q   <= ST_BOOT;
      tap_q     <= '0;
      settle_q  <= '0;
      timer_q   <= '0;
      good_q    <= '0;
      bad_q     <= '0;
      tap_out_q <= DEF_TAP;
      ld_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      settle_q  <= settle_d;
      timer_q   <= timer_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      tap_out_q <= tap_out_d;
      ld_q      <= ld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: begin
        if (bus.idelay_rdy) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.cal_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SET_LAST) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (meas_end) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        state_d = last ? ST_PICK : ST_LOAD;
      end
      ST_PICK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_comb begin
    tap_d     = tap_q;
    settle_d  = settle_q;
    timer_d   = timer_q;
    good_d    = good_q;
    bad_d     = bad_q;
    tap_out_d = tap_out_q;
    ld_d      = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;
    fail_d    = fail_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    unique case (state_q)
      ST_BOOT: begin
        if (bus.idelay_rdy) begin
          tap_out_d = DEF_TAP;
          ld_d      = 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.cal_start) begin
          tap_d  = '0;
          busy_d = 1'b1;
          done_d = 1'b0;
          fail_d = 1'b0;
        end else if (bus.manual_we) begin
          tap_out_d = bus.manual_tap;
          ld_d      = 1'b1;
        end
      end
      ST_LOAD: begin
        tap_out_d = tap_q;
        ld_d      = 1'b1;
        settle_d  = '0;
        timer_d   = '0;
        good_d    = '0;
        bad_d     = '0;
      end
      ST_SETTLE: begin
        settle_d = settle_q + SW'(1);
      end
      ST_MEASURE: begin
        good_d  = good_inc;
        bad_d   = bad_inc;
        timer_d = timer_q + TW'(1);
      end
      ST_EVAL: begin
        if (!last) tap_d = tap_q + TAP_W'(1);
      end
      ST_PICK: begin
        ld_d   = 1'b1;
        busy_d = 1'b0;
        if (best_ok) begin
          tap_out_d = pick_mid;
          done_d    = 1'b1;
          lo_d      = best_start;
          hi_d      = pick_hi;
        end else begin
          tap_out_d = DEF_TAP;
          fail_d    = 1'b1;
          lo_d      = '0;
          hi_d      = '0;
        end
      end
      default: begin
        ld_d = 1'b0;
      end
    endcase
  end

  assign bus.tap_out  = tap_out_q;
  assign bus.tap_ld   = {LANES{ld_q}};
  assign bus.cal_busy = busy_q;
  assign bus.cal_done = done_q;
  assign bus.cal_fail = fail_q;
  assign bus.win_lo   = lo_q;
  assign bus.win_hi   = hi_q;

endmodule

// File: tb/tb_rgmii_idelay_cal.sv
// tb_rgmii_idelay_cal: random PHY model plus scoreboard of expected
// tap loads and sweep results for rgmii_idelay_cal.
module tb_rgmii_idelay_cal;
  import rgmii_pkg::*;

  localparam int DEF = 3;

  typedef struct {
    bit   sweep;
    tap_t tap;
    bit   done;
    bit   fail;
    tap_t lo;
    tap_t hi;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rgmii_idelay_cal_if #(.LANES(5), .TAP_W(5)) bus ();

  rgmii_idelay_cal #(
    .LANES          (5),
    .TAP_W          (5),
    .DEFAULT_TAP    (DEF),
    .SETTLE_CYCLES  (8),
    .DWELL_FRAMES   (16),
    .TIMEOUT_CYCLES (100),
    .MIN_WINDOW     (4)
  ) dut (
    .clk_int (clk),
    .rst_int (rst),
    .bus     (bus)
  );

  always #4 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  logic [31:0] phy_mask   = '0;
  int          phy_dual   = -1;
  bit          phy_silent = 1'b0;

  function automatic void chk(string n, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endfunction

  function automatic exp_t mk_load(int t);
    exp_t e;
    e.sweep = 1'b0;
    e.tap   = tap_t'(t);
    e.done  = 1'b0;
    e.fail  = 1'b0;
    e.lo    = '0;
    e.hi    = '0;
    return e;
  endfunction

  // longest run of passing taps, lowest one on a tie
  function automatic exp_t model(logic [31:0] m);
    exp_t e;
    int bl = 0;
    int bs = 0;
    int cl = 0;
    int cs = 0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        if (cl == 0) cs = i;
        cl++;
        if (cl > bl) begin
          bl = cl;
          bs = cs;
        end
      end else begin
        cl = 0;
      end
    end
    e.sweep = 1'b1;
    if (bl >= 4) begin
      e.done = 1'b1;
      e.fail = 1'b0;
      e.lo   = tap_t'(bs);
      e.hi   = tap_t'(bs + bl - 1);
      e.tap  = tap_t'(bs + bl / 2);
    end else begin
      e.done = 1'b0;
      e.fail = 1'b1;
      e.lo   = '0;
      e.hi   = '0;
      e.tap  = tap_t'(DEF);
    end
    return e;
  endfunction

  // PHY: clean frames on passing taps, errors elsewhere
  initial begin
    bit [31:0] r;
    tap_t      t;
    bus.frame_good = 1'b0;
    bus.frame_bad  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      r = $urandom;
      t = bus.tap_out;
      if (phy_silent) begin
        bus.frame_good = 1'b0;
        bus.frame_bad  = 1'b0;
      end else if (phy_mask[t]) begin
        if (int'(t) == phy_dual) begin
          bus.frame_good = r[0];
          bus.frame_bad  = r[0];
        end else begin
          bus.frame_good = r[0];
          bus.frame_bad  = 1'b0;
        end
      end else begin
        bus.frame_good = r[1] & r[2];
        bus.frame_bad  = r[0];
      end
    end
  end

  // monitor: every load strobe is matched against the scoreboard
  int ld_cnt    = 0;
  bit busy_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      ld_cnt    = 0;
      busy_prev = 1'b0;
    end else begin
      if (bus.tap_ld[0]) begin
        if (bus.cal_busy) begin
          ld_cnt++;
        end else if (exp_q.size() == 0) begin
          chk("unexpected_ld", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ld_kind", int'(busy_prev), int'(e.sweep));
          chk("ld_tap", int'(bus.tap_out), int'(e.tap));
          if (busy_prev) begin
            ld_cnt++;
            chk("sweep_ld_cnt", ld_cnt, 33);
            chk("sweep_done", int'(bus.cal_done), int'(e.done));
            chk("sweep_fail", int'(bus.cal_fail), int'(e.fail));
            chk("sweep_lo", int'(bus.win_lo), int'(e.lo));
            chk("sweep_hi", int'(bus.win_hi), int'(e.hi));
            ld_cnt = 0;
          end
        end
      end
      busy_prev = bus.cal_busy;
    end
  end

  task automatic check_reset_vals();
    chk("rst_tap_out", int'(bus.tap_out), DEF);
    chk("rst_tap_ld", int'(bus.tap_ld), 0);
    chk("rst_busy", int'(bus.cal_busy), 0);
    chk("rst_done", int'(bus.cal_done), 0);
    chk("rst_fail", int'(bus.cal_fail), 0);
    chk("rst_lo", int'(bus.win_lo), 0);
    chk("rst_hi", int'(bus.win_hi), 0);
  endtask

  // caller has raised rst; check, release, then boot load
  task automatic boot_seq();
    bus.idelay_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("boot_wait_ld", int'(bus.tap_ld[0]), 0);
    end
    exp_q.push_back(mk_load(DEF));
    @(posedge clk);
    #1 bus.idelay_rdy = 1'b1;
    @(negedge clk);
    chk("boot_ld_early", int'(bus.tap_ld[0]), 0);
    @(negedge clk);
    chk("boot_ld", int'(bus.tap_ld[0]), 1);
    @(negedge clk);
    chk("boot_ld_len", int'(bus.tap_ld[0]), 0);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 bus.cal_start = 1'b1;
    @(posedge clk);
    #1 bus.cal_start = 1'b0;
  endtask

  task automatic wait_tap_ld(int t);
    bit hit = 1'b0;
    for (int i = 0; i < 8000 && !hit; i++) begin
      @(negedge clk);
      if (bus.tap_ld[0] && bus.cal_busy && bus.tap_out == tap_t'(t))
        hit = 1'b1;
    end
    if (!hit) chk("wait_tap_timeout", 0, 1);
  endtask

  task automatic run_sweep(logic [31:0] m, int dual,
                           bit silent, bit disturb);
    logic [31:0] eff;
    bit          fin = 1'b0;
    eff = silent ? 32'h0 : m;
    if (dual >= 0) eff[dual] = 1'b0;
    phy_mask   = m;
    phy_dual   = dual;
    phy_silent = silent;
    exp_q.push_back(model(eff));
    pulse_start();
    if (disturb) begin
      wait_tap_ld(5);
      @(posedge clk);
      #1;
      bus.manual_tap = 5'd9;
      bus.manual_we  = 1'b1;
      bus.cal_start  = 1'b1;
      @(posedge clk);
      #1;
      bus.manual_we = 1'b0;
      bus.cal_start = 1'b0;
    end
    for (int i = 0; i < 20000 && !fin; i++) begin
      @(negedge clk);
      if (!bus.cal_busy) fin = 1'b1;
    end
    if (!fin) chk("sweep_timeout", 0, 1);
    repeat (3) @(posedge clk);
  endtask

  function automatic logic [31:0] rand_mask();
    logic [31:0] m = '0;
    int lo;
    int len;
    repeat (2) begin
      lo  = $urandom_range(0, 31);
      len = $urandom_range(1, 9);
      for (int i = lo; i < lo + len && i < 32; i++) m[i] = 1'b1;
    end
    return m;
  endfunction

  initial begin
    bus.idelay_rdy = 1'b0;
    bus.cal_start  = 1'b0;
    bus.manual_we  = 1'b0;
    bus.manual_tap = '0;
    boot_seq();

    exp_q.push_back(mk_load(9));
    @(posedge clk);
    #1;
    bus.manual_tap = 5'd9;
    bus.manual_we  = 1'b1;
    @(posedge clk);
    #1 bus.manual_we = 1'b0;
    repeat (3) @(posedge clk);

    run_sweep(32'h001F_FC00, -1, 1'b0, 1'b1);
    run_sweep(32'h0FF0_003C, -1, 1'b0, 1'b0);
    run_sweep(32'h0000_0F0F, -1, 1'b0, 1'b0);
    run_sweep(32'hF000_0000, -1, 1'b0, 1'b0);
    run_sweep(32'h001F_FC00, -1, 1'b1, 1'b0);
    run_sweep(32'h001F_FC00, 15, 1'b0, 1'b0);
    repeat (3) run_sweep(rand_mask(), -1, 1'b0, 1'b0);

    // abort mid-MEASURE at tap 7, no result expected
    phy_mask   = 32'h001F_FC00;
    phy_dual   = -1;
    phy_silent = 1'b0;
    pulse_start();
    wait_tap_ld(7);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    boot_seq();

    run_sweep(rand_mask(), -1, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
